// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for a two-stage fetch/execute pipeline.
// It handles boot, mispredict redirects and halt, and keeps a saturating count of redirects.
module pipeline_hazard_controller #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'('h0000_0200),
  parameter int                 CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iwait,
  input  logic              dwait,
  input  logic              branch_mispredict,
  input  logic [ADDR_W-1:0] branch_jump_addr,
  input  logic              halt_req,
  output logic              fetch_stall,
  output logic              fetch_flush,
  output logic              execute_stall,
  output logic              execute_flush,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_addr,
  output logic              halted,
  output logic [CNT_W-1:0]  mispredict_count
);

  typedef enum logic [1:0] {BOOT, RUN, REDIRECT, HALT} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] redir_addr;
  logic              take_redirect;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= BOOT;
      redir_addr       <= '0;
      mispredict_count <= '0;
    end else begin
      state <= state_next;
      if (take_redirect) begin
        redir_addr <= branch_jump_addr;
        if (mispredict_count != '1)
          mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    take_redirect = 1'b0;
    fetch_stall   = 1'b0;
    fetch_flush   = 1'b0;
    execute_stall = 1'b0;
    execute_flush = 1'b0;
    pc_load       = 1'b0;
    pc_load_addr  = redir_addr;
    halted        = 1'b0;

    if (RST) begin
      fetch_flush   = 1'b1;
      execute_flush = 1'b1;
      pc_load_addr  = '0;
    end else begin
      unique case (state)
        BOOT: begin
          fetch_flush   = 1'b1;
          execute_flush = 1'b1;
          pc_load       = 1'b1;
          pc_load_addr  = RESET_PC;
          state_next    = RUN;
        end
        RUN: begin
          if (dwait) begin
            // Execute holds its instruction, so mispredict/halt are seen again once dwait falls.
            fetch_stall   = 1'b1;
            execute_stall = 1'b1;
          end else if (branch_mispredict) begin
            fetch_flush   = 1'b1;
            execute_flush = 1'b1;
            take_redirect = 1'b1;
            state_next    = REDIRECT;
          end else begin
            execute_flush = iwait;
            if (halt_req)
              state_next = HALT;
          end
        end
        REDIRECT: begin
          // The abandoned fetch must drain before the new PC is accepted.
          fetch_flush   = 1'b1;
          execute_flush = 1'b1;
          pc_load       = 1'b1;
          if (!iwait)
            state_next = RUN;
        end
        HALT: begin
          halted        = 1'b1;
          fetch_stall   = 1'b1;
          execute_stall = 1'b1;
        end
        default: state_next = BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: directed boot/redirect/halt/saturation/reset scenarios, then random stimulus.
// Two DUT instances (default counter width and 4-bit counter) are checked against one reference model.
module tb_pipeline_hazard_controller;
  localparam logic [31:0] RESET_PC = 32'h0000_0200;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iwait = 1'b0, dwait = 1'b0, branch_mispredict = 1'b0, halt_req = 1'b0;
  logic [31:0] branch_jump_addr = '0;

  logic        fetch_stall, fetch_flush, execute_stall, execute_flush, pc_load, halted;
  logic [31:0] pc_load_addr;
  logic [15:0] mispredict_count;
  logic        fetch_stall4, fetch_flush4, execute_stall4, execute_flush4, pc_load4, halted4;
  logic [31:0] pc_load_addr4;
  logic [3:0]  mispredict_count4;

  pipeline_hazard_controller dut (
    .CLK(CLK), .RST(RST), .iwait(iwait), .dwait(dwait),
    .branch_mispredict(branch_mispredict), .branch_jump_addr(branch_jump_addr),
    .halt_req(halt_req), .fetch_stall(fetch_stall), .fetch_flush(fetch_flush),
    .execute_stall(execute_stall), .execute_flush(execute_flush), .pc_load(pc_load),
    .pc_load_addr(pc_load_addr), .halted(halted), .mispredict_count(mispredict_count)
  );

  pipeline_hazard_controller #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .iwait(iwait), .dwait(dwait),
    .branch_mispredict(branch_mispredict), .branch_jump_addr(branch_jump_addr),
    .halt_req(halt_req), .fetch_stall(fetch_stall4), .fetch_flush(fetch_flush4),
    .execute_stall(execute_stall4), .execute_flush(execute_flush4), .pc_load(pc_load4),
    .pc_load_addr(pc_load_addr4), .halted(halted4), .mispredict_count(mispredict_count4)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pipeline phase as flags, redirect count as an unbounded integer.
  bit          m_valid = 1'b0;
  bit          m_boot, m_redir, m_halt;
  logic [31:0] m_target;
  int          m_mispredicts;

  always @(posedge CLK) begin
    if (RST) begin
      m_valid = 1'b1; m_boot = 1'b1; m_redir = 1'b0; m_halt = 1'b0;
      m_target = '0; m_mispredicts = 0;
    end else if (m_valid) begin
      if (m_boot) m_boot = 1'b0;
      else if (m_redir) begin
        if (!iwait) m_redir = 1'b0;
      end else if (!m_halt && !dwait) begin
        if (branch_mispredict) begin
          m_redir = 1'b1; m_target = branch_jump_addr; m_mispredicts++;
        end else if (halt_req) m_halt = 1'b1;
      end
    end
  end

  // Expected control vector: {fetch_stall, fetch_flush, execute_stall, execute_flush, pc_load, halted}
  logic [5:0]  e_ctl;
  logic [31:0] e_addr;

  always @(negedge CLK) begin
    if (m_valid) begin
      e_addr = m_target;
      e_ctl  = 6'b000000;
      if (RST)                    begin e_ctl = 6'b010100; e_addr = '0; end
      else if (m_boot)            begin e_ctl = 6'b010110; e_addr = RESET_PC; end
      else if (m_halt)            e_ctl = 6'b101001;
      else if (m_redir)           e_ctl = 6'b010110;
      else if (dwait)             e_ctl = 6'b101000;
      else if (branch_mispredict) e_ctl = 6'b010100;
      else if (iwait)             e_ctl = 6'b000100;
      check("ctl", 32'({fetch_stall, fetch_flush, execute_stall, execute_flush, pc_load, halted}), 32'(e_ctl));
      check("ctl4", 32'({fetch_stall4, fetch_flush4, execute_stall4, execute_flush4, pc_load4, halted4}), 32'(e_ctl));
      check("addr", pc_load_addr, e_addr);
      check("addr4", pc_load_addr4, e_addr);
      check("cnt", 32'(mispredict_count), (m_mispredicts > 65535) ? 32'd65535 : 32'(m_mispredicts));
      check("cnt4", 32'(mispredict_count4), (m_mispredicts > 15) ? 32'd15 : 32'(m_mispredicts));
      check("inv_fetch", 32'(fetch_stall & fetch_flush), 32'd0);
      check("inv_exec", 32'(execute_stall & execute_flush), 32'd0);
    end
  end

  task automatic drive(input bit rst, input bit iw, input bit dw, input bit bm,
                       input logic [31:0] ba, input bit hr);
    @(posedge CLK);
    #1;
    RST = rst; iwait = iw; dwait = dw; branch_mispredict = bm;
    branch_jump_addr = ba; halt_req = hr;
    #1;
  endtask

  initial begin
    // Boot
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 32'h0, 0);
      check("rst_flushes", 32'({fetch_flush, execute_flush}), 32'h3);
      check("rst_pc_load", 32'(pc_load), 32'd0);
      check("rst_addr", pc_load_addr, 32'h0);
    end
    drive(0, 0, 0, 0, 32'h0, 0);
    check("boot_pc_load", 32'(pc_load), 32'd1);
    check("boot_addr", pc_load_addr, 32'h200);
    check("boot_flushes", 32'({fetch_flush, execute_flush}), 32'h3);
    drive(0, 0, 0, 0, 32'h0, 0);
    check("run_idle", 32'({fetch_stall, fetch_flush, execute_stall, execute_flush, pc_load, halted}), 32'h0);

    // Mispredict with fetch busy
    drive(0, 1, 0, 1, 32'h0000_1234, 0);
    check("mp_flushes", 32'({fetch_flush, execute_flush, pc_load}), 32'h6);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 32'h0, 0);
      check("redir_pc_load", 32'(pc_load), 32'd1);
      check("redir_addr", pc_load_addr, 32'h1234);
    end
    drive(0, 0, 0, 0, 32'h0, 0);
    check("redir_last", 32'(pc_load), 32'd1);
    drive(0, 0, 0, 0, 32'h0, 0);
    check("redir_done", 32'(pc_load), 32'd0);
    check("redir_count", 32'(mispredict_count), 32'd1);

    // dwait priority over mispredict
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 1, 32'h0000_5678, 0);
      check("dw_ctl", 32'({fetch_stall, fetch_flush, execute_stall, execute_flush}), 32'hA);
      check("dw_count", 32'(mispredict_count), 32'd1);
    end
    drive(0, 0, 0, 1, 32'h0000_5678, 0);
    check("dw_mp_flush", 32'({fetch_flush, execute_flush}), 32'h3);
    drive(0, 0, 0, 0, 32'h0, 0);
    check("dw_redir_addr", pc_load_addr, 32'h5678);
    check("dw_count2", 32'(mispredict_count), 32'd2);
    drive(0, 0, 0, 0, 32'h0, 0);

    // Halt while fetch busy
    drive(0, 1, 0, 0, 32'h0, 1);
    check("halt_req_bubble", 32'({execute_flush, halted}), 32'h2);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, i[0], 32'h0000_BEEF, 0);
      check("halt_hold", 32'({fetch_stall, execute_stall, halted, pc_load}), 32'hE);
    end
    drive(1, 0, 0, 0, 32'h0, 0);
    drive(0, 0, 0, 0, 32'h0, 0);
    check("halt_reboot", 32'(pc_load), 32'd1);

    // Counter saturation on the 4-bit instance
    for (int i = 0; i < 17; i++) begin
      drive(0, 0, 0, 1, 32'(i), 0);
      drive(0, 0, 0, 0, 32'h0, 0);
      check("sat_cnt4", 32'(mispredict_count4), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      check("sat_cnt16", 32'(mispredict_count), 32'(i + 1));
    end
    check("sat_final", 32'(mispredict_count4), 32'd15);

    // Reset mid-redirect
    drive(0, 0, 0, 1, 32'h0000_DEAD, 0);
    drive(0, 1, 0, 0, 32'h0, 0);
    drive(1, 1, 0, 0, 32'h0, 0);
    check("rmr_ctl", 32'({fetch_stall, fetch_flush, execute_stall, execute_flush, pc_load, halted}), 32'h14);
    check("rmr_addr", pc_load_addr, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 0);
    check("rmr_boot_addr", pc_load_addr, 32'h200);
    check("rmr_count", 32'(mispredict_count), 32'd0);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(59) == 0, $urandom_range(2) == 0, $urandom_range(3) == 0,
            $urandom_range(5) == 0, $urandom, $urandom_range(29) == 0);
    end
    drive(0, 0, 0, 0, 32'h0, 0);
    @(posedge CLK);
    #6;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
